// File: rtl/ibex_compressed_encoder.sv
// RV32 -> RVC streaming compressor with halfword packer.
// Emits little-endian 32-bit words built from 16/32-bit instruction parcels.
module ibex_compressed_encoder #(
  parameter bit          ENABLE_COMPRESS = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      in_instr_i,
  input  logic             flush_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      out_word_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] cnt_compressed_o
);

  typedef enum logic {
    EMPTY = 1'b0,
    HALF  = 1'b1
  } state_e;

  state_e            state_q;
  logic [15:0]       pend_q;
  logic              out_valid_q;
  logic [31:0]       out_word_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [6:0]  opc;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [11:0] imm_i, imm_s;

  assign opc   = in_instr_i[6:0];
  assign rd    = in_instr_i[11:7];
  assign f3    = in_instr_i[14:12];
  assign rs1   = in_instr_i[19:15];
  assign rs2   = in_instr_i[24:20];
  assign f7    = in_instr_i[31:25];
  assign imm_i = in_instr_i[31:20];
  assign imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

  logic is_addi, is_op, is_lw, is_sw, is_jalr, is_ebrk;
  logic imm6, i_zero, lw_ok, sw_ok, lwsp_ok, swsp_ok;
  logic rd_c, rs1_c, rs2_c;
  logic op_add, op_alu;
  logic [1:0] alu_fn;

  assign is_addi = (opc == 7'h13) && (f3 == 3'd0);
  assign is_op   = (opc == 7'h33);
  assign is_lw   = (opc == 7'h03) && (f3 == 3'd2);
  assign is_sw   = (opc == 7'h23) && (f3 == 3'd2);
  assign is_jalr = (opc == 7'h67) && (f3 == 3'd0)
                && (imm_i == 12'd0) && (rs1 != 5'd0);
  assign is_ebrk = (in_instr_i == 32'h0010_0073);

  // Signed 6-bit range check: bits 11..5 must all match.
  assign imm6    = (&imm_i[11:5]) || !(|imm_i[11:5]);
  assign i_zero  = (imm_i == 12'd0);
  assign lw_ok   = (imm_i[11:7] == 5'd0) && (imm_i[1:0] == 2'd0);
  assign sw_ok   = (imm_s[11:7] == 5'd0) && (imm_s[1:0] == 2'd0);
  assign lwsp_ok = (imm_i[11:8] == 4'd0) && (imm_i[1:0] == 2'd0);
  assign swsp_ok = (imm_s[11:8] == 4'd0) && (imm_s[1:0] == 2'd0);

  assign rd_c  = (rd[4:3] == 2'b01);
  assign rs1_c = (rs1[4:3] == 2'b01);
  assign rs2_c = (rs2[4:3] == 2'b01);

  assign op_add = is_op && (f7 == 7'h00) && (f3 == 3'd0);

  // SUB/XOR/OR/AND selector and their CA-format funct2.
  always_comb begin
    op_alu = 1'b0;
    alu_fn = 2'b00;
    if (is_op) begin
      if (f7 == 7'h20 && f3 == 3'd0) begin
        op_alu = 1'b1;
        alu_fn = 2'b00;
      end else if (f7 == 7'h00 && f3 == 3'd4) begin
        op_alu = 1'b1;
        alu_fn = 2'b01;
      end else if (f7 == 7'h00 && f3 == 3'd6) begin
        op_alu = 1'b1;
        alu_fn = 2'b10;
      end else if (f7 == 7'h00 && f3 == 3'd7) begin
        op_alu = 1'b1;
        alu_fn = 2'b11;
      end
    end
  end

  logic        enc_ok;
  logic [15:0] enc_h;

  // Rule conditions are mutually exclusive, so order is implicit.
  always_comb begin
    enc_ok = 1'b0;
    enc_h  = 16'h0000;
    if (ENABLE_COMPRESS && in_instr_i[1:0] == 2'b11) begin
      unique case (1'b1)
        (is_addi && rd == 5'd0 && rs1 == 5'd0 && i_zero): begin
          enc_ok = 1'b1;
          enc_h  = 16'h0001;
        end
        (is_addi && rd != 5'd0 && rd == rs1 && !i_zero && imm6): begin
          enc_ok = 1'b1;
          enc_h  = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end
        (is_addi && rd != 5'd0 && rs1 == 5'd0 && imm6): begin
          enc_ok = 1'b1;
          enc_h  = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end
        (is_addi && rd != 5'd0 && rs1 != 5'd0 && i_zero): begin
          enc_ok = 1'b1;
          enc_h  = {4'b1000, rd, rs1, 2'b10};
        end
        (op_add && rd != 5'd0 && rd == rs1 && rs2 != 5'd0): begin
          enc_ok = 1'b1;
          enc_h  = {4'b1001, rd, rs2, 2'b10};
        end
        (op_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0): begin
          enc_ok = 1'b1;
          enc_h  = {4'b1000, rd, rs2, 2'b10};
        end
        (op_alu && rd == rs1 && rd_c && rs2_c): begin
          enc_ok = 1'b1;
          enc_h  = {6'b100011, rd[2:0], alu_fn, rs2[2:0], 2'b01};
        end
        (is_lw && rs1_c && rd_c && lw_ok): begin
          enc_ok = 1'b1;
          enc_h  = {3'b010, imm_i[5:3], rs1[2:0],
                    imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end
        (is_sw && rs1_c && rs2_c && sw_ok): begin
          enc_ok = 1'b1;
          enc_h  = {3'b110, imm_s[5:3], rs1[2:0],
                    imm_s[2], imm_s[6], rs2[2:0], 2'b00};
        end
        (is_lw && rd != 5'd0 && rs1 == 5'd2 && lwsp_ok): begin
          enc_ok = 1'b1;
          enc_h  = {3'b010, imm_i[5], rd,
                    imm_i[4:2], imm_i[7:6], 2'b10};
        end
        (is_sw && rs1 == 5'd2 && swsp_ok): begin
          enc_ok = 1'b1;
          enc_h  = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end
        (is_jalr && rd == 5'd0): begin
          enc_ok = 1'b1;
          enc_h  = {4'b1000, rs1, 5'd0, 2'b10};
        end
        (is_jalr && rd == 5'd1): begin
          enc_ok = 1'b1;
          enc_h  = {4'b1001, rs1, 5'd0, 2'b10};
        end
        is_ebrk: begin
          enc_ok = 1'b1;
          enc_h  = 16'h9002;
        end
        default: begin
          enc_ok = 1'b0;
          enc_h  = 16'h0000;
        end
      endcase
    end
  end

  logic        is_c;
  logic [15:0] half;
  logic        slot_free, accept, flush_go;

  assign is_c      = (in_instr_i[1:0] != 2'b11) || enc_ok;
  assign half      = enc_ok ? enc_h : in_instr_i[15:0];
  assign slot_free = !out_valid_q || out_ready_i;
  assign accept    = in_valid_i && slot_free;
  assign flush_go  = flush_i && !in_valid_i && slot_free
                  && (state_q == HALF);

  // Packing FSM, output slot and saturating counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= EMPTY;
      pend_q      <= 16'h0000;
      out_valid_q <= 1'b0;
      out_word_q  <= 32'h0;
      cnt_q       <= '0;
    end else begin
      if (out_ready_i) out_valid_q <= 1'b0;
      if (accept) begin
        if (is_c && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
        unique case (state_q)
          EMPTY: begin
            if (is_c) begin
              pend_q  <= half;
              state_q <= HALF;
            end else begin
              out_word_q  <= in_instr_i;
              out_valid_q <= 1'b1;
            end
          end
          HALF: begin
            out_valid_q <= 1'b1;
            if (is_c) begin
              out_word_q <= {half, pend_q};
              state_q    <= EMPTY;
            end else begin
              out_word_q <= {in_instr_i[15:0], pend_q};
              pend_q     <= in_instr_i[31:16];
            end
          end
          default: state_q <= EMPTY;
        endcase
      end else if (flush_go) begin
        out_word_q  <= {16'h0001, pend_q};
        out_valid_q <= 1'b1;
        state_q     <= EMPTY;
      end
    end
  end

  assign in_ready_o       = slot_free;
  assign out_valid_o      = out_valid_q;
  assign out_word_o       = out_word_q;
  assign pending_o        = (state_q == HALF);
  assign cnt_compressed_o = cnt_q;

endmodule
